// File: rtl/y86_defs.sv
// Y86-64 shared encodings: instruction codes, register IDs and status codes.
// Fetch, execute and memory import this package as well.
package y86_defs;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RRSP  = 4'h4;
   localparam logic [3:0] RNONE = 4'hF;

   localparam logic [1:0] SAOK = 2'd0;
   localparam logic [1:0] SHLT = 2'd1;
   localparam logic [1:0] SINS = 2'd2;

   localparam int NREGS = 15;

   function automatic logic icode_valid(input logic [3:0] ic);
      return ic <= IPOPQ;
   endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// 15-entry register file: two combinational read ports, a debug read port,
// and two write ports where port M overrides port E on the same address.
module regfile_2r2w
   import y86_defs::*;
#(
   parameter int                 DATA_W   = 64,
   parameter logic [DATA_W-1:0]  RESET_SP = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_e_i,
   input  logic [3:0]        addr_e_i,
   input  logic [DATA_W-1:0] data_e_i,
   input  logic              we_m_i,
   input  logic [3:0]        addr_m_i,
   input  logic [DATA_W-1:0] data_m_i,
   input  logic [3:0]        addr_a_i,
   output logic [DATA_W-1:0] data_a_o,
   input  logic [3:0]        addr_b_i,
   output logic [DATA_W-1:0] data_b_o,
   input  logic [3:0]        addr_dbg_i,
   output logic [DATA_W-1:0] data_dbg_o
);

   logic [DATA_W-1:0] regs_q [0:NREGS-1];

   // ID F is the "no register" encoding and always reads as zero.
   function automatic logic [DATA_W-1:0] rd(input logic [3:0] a);
      if (a == RNONE) return '0;
      return regs_q[a];
   endfunction

   assign data_a_o   = rd(addr_a_i);
   assign data_b_o   = rd(addr_b_i);
   assign data_dbg_o = rd(addr_dbg_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= (i == int'(RRSP)) ? RESET_SP : '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (we_m_i && addr_m_i == i[3:0])
               regs_q[i] <= data_m_i;
            else if (we_e_i && addr_e_i == i[3:0])
               regs_q[i] <= data_e_i;
         end
      end
   end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/write-back: register-ID decode, operand reads, result
// commit, condition codes and processor status.
module decode_writeback
   import y86_defs::*;
#(
   parameter int                 DATA_W   = 64,
   parameter logic [DATA_W-1:0]  RESET_SP = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en,
   input  logic [3:0]        icode,
   input  logic [3:0]        ra,
   input  logic [3:0]        rb,
   input  logic              cnd,
   input  logic [DATA_W-1:0] vale,
   input  logic [DATA_W-1:0] valm,
   input  logic              zf_in,
   input  logic              sf_in,
   input  logic              of_in,
   output logic [3:0]        srca,
   output logic [3:0]        srcb,
   output logic [3:0]        dste,
   output logic [3:0]        dstm,
   output logic [DATA_W-1:0] vala,
   output logic [DATA_W-1:0] valb,
   output logic              cc_z,
   output logic              cc_s,
   output logic              cc_o,
   output logic [1:0]        stat,
   input  logic [3:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [1:0] stat_q, stat_d;
   logic [2:0] cc_q, cc_d;
   logic       commit;

   always_comb begin
      srca = RNONE;
      srcb = RNONE;
      dste = RNONE;
      dstm = RNONE;
      case (icode)
         IRRMOVQ: begin srca = ra; dste = cnd ? rb : RNONE; end
         IIRMOVQ: dste = rb;
         IRMMOVQ: begin srca = ra; srcb = rb; end
         IMRMOVQ: begin srcb = rb; dstm = ra; end
         IOPQ:    begin srca = ra; srcb = rb; dste = rb; end
         ICALL:   begin srcb = RRSP; dste = RRSP; end
         IRET:    begin srca = RRSP; srcb = RRSP; dste = RRSP; end
         IPUSHQ:  begin srca = ra; srcb = RRSP; dste = RRSP; end
         IPOPQ:   begin srca = RRSP; srcb = RRSP; dste = RRSP; dstm = ra; end
         default: ;
      endcase
   end

   // halt and illegal icodes change status only; they never write state
   assign commit = wb_en && (stat_q == SAOK) && (icode != IHALT) && icode_valid(icode);

   always_comb begin
      stat_d = stat_q;
      if (wb_en && stat_q == SAOK) begin
         if (icode == IHALT)
            stat_d = SHLT;
         else if (!icode_valid(icode))
            stat_d = SINS;
      end
   end

   always_comb begin
      cc_d = cc_q;
      if (commit && icode == IOPQ)
         cc_d = {zf_in, sf_in, of_in};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_q <= SAOK;
         cc_q   <= 3'b100;
      end else begin
         stat_q <= stat_d;
         cc_q   <= cc_d;
      end
   end

   assign stat = stat_q;
   assign {cc_z, cc_s, cc_o} = cc_q;

   regfile_2r2w #(
      .DATA_W   (DATA_W),
      .RESET_SP (RESET_SP)
   ) u_rf (
      .clk        (clk),
      .rst        (rst),
      .we_e_i     (commit && dste != RNONE),
      .addr_e_i   (dste),
      .data_e_i   (vale),
      .we_m_i     (commit && dstm != RNONE),
      .addr_m_i   (dstm),
      .data_m_i   (valm),
      .addr_a_i   (srca),
      .data_a_o   (vala),
      .addr_b_i   (srcb),
      .data_b_o   (valb),
      .addr_dbg_i (dbg_addr),
      .data_dbg_o (dbg_data)
   );

endmodule
